// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op/state encodings and op classification for seq_alu
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_MUL  = 3'b010,
    ALU_MULH = 3'b011,
    ALU_DIV  = 3'b100,
    ALU_MOD  = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_iterative(alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - link between the ALU control path and the shift-add/restoring core
interface seq_alu_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  is_div;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  last;
  logic [DATA_WIDTH-1:0] res_hi;
  logic [DATA_WIDTH-1:0] res_lo;

  modport master (output start, is_div, op_a, op_b, input last, res_hi, res_lo);
  modport slave  (input start, is_div, op_a, op_b, output last, res_hi, res_lo);
endinterface

// File: rtl/seq_alu_muldiv_core.sv
// rtl/seq_alu_muldiv_core.sv - unsigned shift-add multiply / restoring divide, one bit per clock
module seq_alu_muldiv_core #(
  parameter int DATA_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave core_if
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [2*W-1:0]   r_acc;
  logic [W-1:0]     r_opnd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_is_div;

  logic [2*W-1:0] w_acc_cur;
  logic [2*W-1:0] w_acc_next;
  logic [W-1:0]   w_opnd_cur;
  logic           w_div_cur;
  logic [W:0]     w_x;
  logic [W:0]     w_y;
  logic           w_cin;
  logic [W+1:0]   w_sum;

  // The first iteration is folded into the load edge, so W steps finish on the (W-1)th busy edge.
  assign w_acc_cur  = core_if.start ? {{W{1'b0}}, core_if.op_a} : r_acc;
  assign w_opnd_cur = core_if.start ? core_if.op_b : r_opnd;
  assign w_div_cur  = core_if.start ? core_if.is_div : r_is_div;

  always_comb begin
    w_x   = {1'b0, w_acc_cur[2*W-1:W]};
    w_y   = {1'b0, w_opnd_cur};
    w_cin = 1'b0;
    if (w_div_cur) begin
      w_x   = w_acc_cur[2*W-1:W-1];
      w_y   = ~{1'b0, w_opnd_cur};
      w_cin = 1'b1;
    end
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{(W+1){1'b0}}, w_cin};

  // Divide: w_sum[W+1] is the no-borrow bit of (shifted remainder - divisor).
  always_comb begin
    if (w_div_cur) begin
      w_acc_next = w_sum[W+1] ? {w_sum[W-1:0], w_acc_cur[W-2:0], 1'b1}
                              : {w_acc_cur[2*W-2:0], 1'b0};
    end else begin
      w_acc_next = w_acc_cur[0] ? {w_sum[W:0], w_acc_cur[W-1:1]}
                                : {1'b0, w_acc_cur[2*W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
    end else if (core_if.start) begin
      r_acc    <= w_acc_next;
      r_opnd   <= core_if.op_b;
      r_is_div <= core_if.is_div;
      r_cnt    <= CNT_W'(W - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign core_if.last   = r_busy && (r_cnt == CNT_W'(1));
  assign core_if.res_hi = r_acc[2*W-1:W];
  assign core_if.res_lo = r_acc[W-1:0];

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle integer ALU: handshake FSM, ADD/SUB, sign fix-up and flags
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_alu_input_a,
  input  logic [DATA_WIDTH-1:0] i_alu_input_b,
  input  logic [2:0]            i_alu_input_op,
  input  logic                  i_alu_input_signed,
  input  logic                  i_alu_input_valid,
  output logic                  o_alu_input_ready,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic                  o_alu_error,
  output logic                  o_alu_overflow,
  output logic                  o_alu_result_valid,
  input  logic                  i_alu_result_ready
);
  localparam int W = DATA_WIDTH;

  state_e       r_state, w_next;
  alu_op_e      r_op;
  logic         r_signed, r_neg_a, r_neg_b;
  logic [W-1:0] r_result;
  logic         r_error, r_overflow, r_valid;

  alu_op_e        w_op;
  logic           w_neg_a, w_neg_b, w_err, w_iter, w_is_sub;
  logic [W-1:0]   w_abs_a, w_abs_b, w_as_res;
  logic [W:0]     w_add, w_sub;
  logic           w_as_ovf;
  logic           w_res_neg;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quot, w_rem, w_fix_res;
  logic           w_fix_ovf;

  seq_alu_if #(.DATA_WIDTH(W)) u_core_if ();
  seq_alu_muldiv_core #(.DATA_WIDTH(W)) u_core (.clk(clk), .rst_n(rst_n), .core_if(u_core_if));

  assign w_op     = alu_op_e'(i_alu_input_op);
  assign w_err    = (i_alu_input_op[2:1] == 2'b11) ||
                    (((w_op == ALU_DIV) || (w_op == ALU_MOD)) && (i_alu_input_b == '0));
  assign w_iter   = is_iterative(w_op);
  assign w_is_sub = (w_op == ALU_SUB);
  assign w_neg_a  = i_alu_input_signed & i_alu_input_a[W-1];
  assign w_neg_b  = i_alu_input_signed & i_alu_input_b[W-1];
  assign w_abs_a  = w_neg_a ? -i_alu_input_a : i_alu_input_a;
  assign w_abs_b  = w_neg_b ? -i_alu_input_b : i_alu_input_b;

  assign w_add    = {1'b0, i_alu_input_a} + {1'b0, i_alu_input_b};
  assign w_sub    = {1'b0, i_alu_input_a} - {1'b0, i_alu_input_b};
  assign w_as_res = w_is_sub ? w_sub[W-1:0] : w_add[W-1:0];

  always_comb begin
    w_as_ovf = w_is_sub ? w_sub[W] : w_add[W];
    if (i_alu_input_signed) begin
      w_as_ovf = ((i_alu_input_a[W-1] ^ i_alu_input_b[W-1]) == w_is_sub) &&
                 (w_as_res[W-1] != i_alu_input_a[W-1]);
    end
  end

  assign u_core_if.start  = (r_state == S_IDLE) && i_alu_input_valid && w_iter && !w_err;
  assign u_core_if.is_div = (w_op == ALU_DIV) || (w_op == ALU_MOD);
  assign u_core_if.op_a   = w_abs_a;
  assign u_core_if.op_b   = w_abs_b;

  // Core works on magnitudes; signs are re-applied here. Unsigned ops have both neg flags clear.
  assign w_res_neg = r_neg_a ^ r_neg_b;
  assign w_prod    = w_res_neg ? -{u_core_if.res_hi, u_core_if.res_lo}
                               : {u_core_if.res_hi, u_core_if.res_lo};
  assign w_quot    = w_res_neg ? -u_core_if.res_lo : u_core_if.res_lo;
  assign w_rem     = r_neg_a ? -u_core_if.res_hi : u_core_if.res_hi;

  always_comb begin
    w_fix_res = '0;
    w_fix_ovf = 1'b0;
    case (r_op)
      ALU_MUL: begin
        w_fix_res = w_prod[W-1:0];
        w_fix_ovf = r_signed ? (w_prod[2*W-1:W] != {W{w_prod[W-1]}}) : (w_prod[2*W-1:W] != '0);
      end
      ALU_MULH: w_fix_res = w_prod[2*W-1:W];
      ALU_DIV: begin
        w_fix_res = w_quot;
        w_fix_ovf = r_signed && !w_res_neg && u_core_if.res_lo[W-1];
      end
      ALU_MOD: w_fix_res = w_rem;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_alu_input_valid) w_next = (w_iter && !w_err) ? S_CALC : S_DONE;
      S_CALC: if (u_core_if.last) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (i_alu_result_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= ALU_ADD;
      r_signed   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_result   <= '0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_alu_input_valid) begin
          r_op       <= w_op;
          r_signed   <= i_alu_input_signed;
          r_neg_a    <= w_neg_a;
          r_neg_b    <= w_neg_b;
          r_error    <= w_err;
          r_result   <= (w_err || w_iter) ? '0 : w_as_res;
          r_overflow <= !w_err && !w_iter && w_as_ovf;
          r_valid    <= w_err || !w_iter;
        end
        S_FIX: begin
          r_result   <= w_fix_res;
          r_overflow <= w_fix_ovf;
          r_valid    <= 1'b1;
        end
        S_DONE: if (i_alu_result_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_alu_input_ready  = (r_state == S_IDLE);
  assign o_alu_result       = r_result;
  assign o_alu_error        = r_error;
  assign o_alu_overflow     = r_overflow;
  assign o_alu_result_valid = r_valid;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (DATA_WIDTH=16)
module tb_seq_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_i, b_i, res_o;
  logic [2:0]   op_i;
  logic         sgn_i, in_valid, in_ready, res_ready, err_o, ovf_o, res_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_alu_input_a      (a_i),
    .i_alu_input_b      (b_i),
    .i_alu_input_op     (op_i),
    .i_alu_input_signed (sgn_i),
    .i_alu_input_valid  (in_valid),
    .o_alu_input_ready  (in_ready),
    .o_alu_result       (res_o),
    .o_alu_error        (err_o),
    .o_alu_overflow     (ovf_o),
    .o_alu_result_valid (res_valid),
    .i_alu_result_ready (res_ready)
  );

  typedef struct {
    logic [2:0]   op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         err;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic on the operands' numeric values.
  function automatic void model(input logic [2:0] op, input logic sgn, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] res,
                                output logic err, output logic ovf);
    longint va, vb, r;
    va  = sgn ? longint'($signed(a)) : longint'(a);
    vb  = sgn ? longint'($signed(b)) : longint'(b);
    r   = 0;
    res = '0;
    err = 1'b0;
    ovf = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        r   = (op == 3'd0) ? va + vb : (op == 3'd1) ? va - vb : va * vb;
        res = r[W-1:0];
        ovf = sgn ? (r > 32767 || r < -32768) : (r > 65535 || r < 0);
      end
      3'd3: begin
        r   = va * vb;
        res = r[2*W-1:W];
      end
      3'd4, 3'd5: begin
        if (vb == 0) err = 1'b1;
        else begin
          r   = (op == 3'd4) ? va / vb : va % vb;
          res = r[W-1:0];
          ovf = sgn && (op == 3'd4) && (r > 32767);
        end
      end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] res, output logic err,
                       output logic ovf, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("input_ready_before_issue", in_ready, 1);
    op_i = op; sgn_i = sgn; a_i = a; b_i = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = res_o; err = err_o; ovf = ovf_o;
  endtask

  task automatic finish_op;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r, er, hold;
    logic         e, o, ee, eo;
    int           l, el;

    vecs[0]  = '{3'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vecs[1]  = '{3'd1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1};
    vecs[2]  = '{3'd2, 1'b1, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b0, 17};
    vecs[3]  = '{3'd3, 1'b0, 16'h8000, 16'h0004, 16'h0002, 1'b0, 1'b0, 17};
    vecs[4]  = '{3'd2, 1'b0, 16'h8000, 16'h0004, 16'h0000, 1'b0, 1'b1, 17};
    vecs[5]  = '{3'd4, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 1'b0, 17};
    vecs[6]  = '{3'd5, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[7]  = '{3'd4, 1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 1'b0, 1'b0, 17};
    vecs[8]  = '{3'd4, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1};
    vecs[9]  = '{3'd6, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1};
    vecs[10] = '{3'd4, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 17};
    vecs[11] = '{3'd5, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
    vecs[12] = '{3'd3, 1'b1, 16'h8000, 16'h8000, 16'h4000, 1'b0, 1'b0, 17};

    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    a_i = '0; b_i = '0; op_i = '0; sgn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", res_valid, 0);
    check("reset_result", res_o, 0);
    check("reset_error", err_o, 0);
    check("reset_overflow", ovf_o, 0);
    check("reset_input_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, r, e, o, l);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_error", i), e, vecs[i].err);
      check($sformatf("vec%0d_overflow", i), o, vecs[i].ovf);
      check($sformatf("vec%0d_latency", i), l, vecs[i].lat);
      finish_op();
      check($sformatf("vec%0d_ready_after_accept", i), in_ready, 1);
    end

    for (int i = 0; i < 300; i++) begin
      logic [2:0]   rop;
      logic         rsg;
      logic [W-1:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      rsg = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1:       rb = 16'hFFFF;
        2:       rb = 16'($urandom_range(1, 8));
        default: rb = 16'($urandom);
      endcase
      model(rop, rsg, ra, rb, er, ee, eo);
      el = (rop < 3'd2 || ee) ? 1 : W + 1;
      do_op(rop, rsg, ra, rb, r, e, o, l);
      check($sformatf("rnd%0d_op%0d_result", i, rop), r, er);
      check($sformatf("rnd%0d_op%0d_error", i, rop), e, ee);
      check($sformatf("rnd%0d_op%0d_overflow", i, rop), o, eo);
      check($sformatf("rnd%0d_op%0d_latency", i, rop), l, el);
      finish_op();
    end

    model(3'd2, 1'b0, 16'h1234, 16'h0010, er, ee, eo);
    do_op(3'd2, 1'b0, 16'h1234, 16'h0010, r, e, o, l);
    check("bp_initial_result", r, er);
    hold = r;
    op_i = 3'd0; a_i = 16'h1111; b_i = 16'h2222; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_result_stable", res_o, hold);
      check("bp_overflow_stable", ovf_o, eo);
      check("bp_valid_held", res_valid, 1);
      check("bp_input_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    finish_op();
    check("bp_valid_dropped", res_valid, 0);
    check("bp_input_ready_back", in_ready, 1);
    do_op(3'd0, 1'b0, 16'h0001, 16'h0001, r, e, o, l);
    check("bp_next_add_result", r, 16'h0002);
    check("bp_next_add_latency", l, 1);
    finish_op();

    check("rst_test_ready", in_ready, 1);
    op_i = 3'd2; sgn_i = 1'b1; a_i = 16'h0123; b_i = 16'h0456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midcalc_reset_valid", res_valid, 0);
    check("midcalc_reset_result", res_o, 0);
    check("midcalc_reset_input_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("midcalc_discarded", res_valid, 0);
    do_op(3'd0, 1'b0, 16'h0003, 16'h0004, r, e, o, l);
    check("post_reset_add_result", r, 16'h0007);
    check("post_reset_add_error", e, 0);
    check("post_reset_add_overflow", o, 0);
    check("post_reset_add_latency", l, 1);
    finish_op();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
